ddr2_aref: RTL and testbench
============================

Name: ddr2_aref

Overview:
- Periodic auto-refresh sequencer for the DDR2 controller; sits directly downstream of the power-up init sequencer and becomes active once `init_end` asserts.
- Times the tREFI interval and raises a refresh request to the command arbiter.
- On grant, drives the precharge-all / tRP / AUTO REFRESH / tRFC sequence onto its command bus, then pulses done.

Parameters:
- `BA_BITS`, 3, bank address width.
- `ADDR_BITS`, 14, row/column address width.
- `tCK`, 5, clock period in ns.
- `tREFI`, 7800, average refresh interval in ns; `REFI_CYC` = tREFI/tCK (integer division).
- `tRP`, 15, precharge period in ns; `RP_CYC` = tRP/tCK, minimum 1.
- `tRFC`, 130, refresh cycle time in ns; `RFC_CYC` = tRFC/tCK, minimum 1.
- `MAX_PEND`, 8, maximum postponed refreshes held (JEDEC DDR2 limit).

Ports:
- `clk`  in  1  controller clock.
- `rst_n`  in  1  reset.
- `init_end`  in  1  init sequence complete; level, monotonic after reset.
- `aref_en`  in  1  arbiter grant; sampled only while `aref_req`=1 and FSM in IDLE.
- `aref_req`  out  1  refresh pending request to arbiter.
- `aref_cmd`  out  4  {cs_n,ras_n,cas_n,we_n}: NOP=4'b0111, PRE=4'b0010, AREF=4'b0001.
- `aref_ba`  out  BA_BITS  bank address; always 0.
- `aref_addr`  out  ADDR_BITS  address; A10=1 during PRE, else 0.
- `aref_end`  out  1  one-cycle pulse, sequence complete; arbiter releases bus.
- `aref_ovf`  out  1  sticky; pending count would have exceeded `MAX_PEND`.

Behaviour:
- Reset is asynchronous, active-low on `rst_n`; clock is `clk`. All logic is `clk`-rising-edge registered.
- Reset values: `aref_req`=0, `aref_cmd`=NOP, `aref_ba`=0, `aref_addr`=0, `aref_end`=0, `aref_ovf`=0, `pend`=0, `refi_cnt`=0, FSM=IDLE.
- Interval counter:
  - `refi_cnt` counts 0..`REFI_CYC`-1 while `init_end`=1 and wraps to 0.
  - Wrap edge = tick. Tick increments `pend`.
  - `init_end`=0 holds `refi_cnt` and `pend` at 0. An in-flight sequence still completes.
- Pending count: `pend` is a 0..MAX_PEND counter.
  - Tick with `pend`=MAX_PEND: `pend` holds and `aref_ovf` sets (sticky until reset).
  - Tick coinciding with a completion decrement: net change 0.
- `aref_req` = (`pend`>0) and FSM==IDLE, registered. It drops the cycle after the grant is accepted.
- FSM states, with outputs registered (visible the cycle after state entry):
  - IDLE: cmd=NOP. If `aref_req`&`aref_en` -> PRE.
  - PRE: cmd=PRE, `addr[10]`=1, for 1 cycle -> WAIT_RP.
  - WAIT_RP: cmd=NOP for `RP_CYC`-1 cycles -> AREF. PRE-to-AREF spacing is exactly `RP_CYC` clocks.
  - AREF: cmd=AREF for 1 cycle; `pend` decrements -> WAIT_RFC.
  - WAIT_RFC: cmd=NOP for `RFC_CYC`-1 cycles -> DONE.
  - DONE: `aref_end`=1 for 1 cycle, cmd=NOP -> IDLE.
- `aref_en` is ignored outside IDLE.
- Grant-to-PRE latency: PRE appears on `aref_cmd` 1 cycle after the accepting edge.
- Total bus occupancy per refresh = 1+`RP_CYC`+`RFC_CYC` cycles, counted from PRE to `aref_end` inclusive.
- Reset mid-sequence: immediate return to reset values. No partial command persists.

Optional Feature:
- Macro: `AREF_BURST_EN`.
- Defined: in AREF, if `pend`>1 after decrement, WAIT_RFC returns to AREF instead of DONE. This drains all pending refreshes back-to-back, AREF-to-AREF spacing `RFC_CYC`, with a single PRE and a single `aref_end` at the end. Ticks arriving mid-burst are also drained.
- Undefined: exactly one AREF per grant, as described in Behaviour.

Test Plan:
- Test parameters: tREFI=40, tRP=15, tRFC=30, tCK=5.
- Reset hold, `init_end`=0 for 100 cycles -> `aref_req`=0, `aref_cmd`=7, `pend`=0 throughout.
- Single refresh: `init_end`=1, `aref_en` tied 1 -> `aref_req` rises after 8 cycles. Then PRE (`addr`=0x0400), NOP, NOP, AREF at PRE+3, then `aref_end` pulse at AREF+6; `aref_req`=0 afterwards.
- Postponed refresh: hold `aref_en`=0 for 8 ticks, then grant once -> `pend` 8 -> 7, `aref_req` stays 1 after `aref_end`, `aref_ovf`=0. A 9th tick without grant -> `aref_ovf`=1, `pend`=8.
- Tick coincident with the AREF cycle -> `pend` unchanged across that edge.
- Async reset asserted in WAIT_RFC -> all outputs at reset values same cycle. After release and `init_end`=1, the first request comes after a full 8-cycle interval.
- `AREF_BURST_EN` with `pend`=3 at grant -> one PRE, three AREFs spaced 6 cycles apart, one `aref_end`, `pend`=0.

Source files
------------

// File: rtl/ddr2_aref.sv
// DDR2 periodic auto-refresh sequencer: times tREFI, requests the bus, then issues PRE-all / AREF.
// Optional macro AREF_BURST_EN drains every pending refresh back-to-back under a single grant.
module ddr2_aref #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int tCK       = 5,
  parameter int tREFI     = 7800,
  parameter int tRP       = 15,
  parameter int tRFC      = 130,
  parameter int MAX_PEND  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_end,
  input  logic                 aref_en,
  output logic                 aref_req,
  output logic [3:0]           aref_cmd,
  output logic [BA_BITS-1:0]   aref_ba,
  output logic [ADDR_BITS-1:0] aref_addr,
  output logic                 aref_end,
  output logic                 aref_ovf
);

  localparam int REFI_CYC = tREFI / tCK;
  localparam int RP_RAW   = tRP / tCK;
  localparam int RFC_RAW  = tRFC / tCK;
  localparam int RP_CYC   = (RP_RAW  < 1) ? 1 : RP_RAW;
  localparam int RFC_CYC  = (RFC_RAW < 1) ? 1 : RFC_RAW;
  localparam int CNT_W    = (REFI_CYC > 1) ? $clog2(REFI_CYC) : 1;
  localparam int PEND_W   = $clog2(MAX_PEND + 1);
  localparam int WAIT_MAX = (RP_CYC > RFC_CYC) ? RP_CYC : RFC_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [CNT_W-1:0]     REFI_LAST = CNT_W'(REFI_CYC - 1);
  localparam logic [PEND_W-1:0]    PEND_MAX  = PEND_W'(MAX_PEND);
  localparam logic [WAIT_W-1:0]    RP_LAST   = WAIT_W'((RP_CYC  > 1) ? RP_CYC  - 2 : 0);
  localparam logic [WAIT_W-1:0]    RFC_LAST  = WAIT_W'((RFC_CYC > 1) ? RFC_CYC - 2 : 0);
  localparam logic [ADDR_BITS-1:0] ADDR_A10  = ADDR_BITS'(1) << 10;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE      = 3'd1,
    ST_WAIT_RP  = 3'd2,
    ST_AREF     = 3'd3,
    ST_WAIT_RFC = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    refi_cnt_r, refi_cnt_s;
  logic [PEND_W-1:0]   pend_r, pend_s;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_s;
  logic                tick_s, dec_s, ovf_s;
  logic                aref_req_r, aref_end_r, aref_ovf_r;
  logic [3:0]          aref_cmd_r;
  logic [ADDR_BITS-1:0] aref_addr_r;

  function automatic logic [3:0] cmd_of(input state_t st);
    case (st)
      ST_PRE:  cmd_of = CMD_PRE;
      ST_AREF: cmd_of = CMD_AREF;
      default: cmd_of = CMD_NOP;
    endcase
  endfunction

  assign tick_s = init_end && (refi_cnt_r == REFI_LAST);
  assign dec_s  = (state_r == ST_AREF) && (pend_r != '0);

  // Interval counter and pending-refresh bookkeeping; a tick and a decrement together cancel.
  always_comb begin
    refi_cnt_s = refi_cnt_r;
    pend_s     = pend_r;
    ovf_s      = aref_ovf_r;
    if (!init_end) begin
      refi_cnt_s = '0;
      pend_s     = '0;
    end else begin
      refi_cnt_s = tick_s ? '0 : refi_cnt_r + CNT_W'(1);
      if (tick_s && !dec_s) begin
        if (pend_r == PEND_MAX) begin
          ovf_s = 1'b1;
        end else begin
          pend_s = pend_r + PEND_W'(1);
        end
      end else if (dec_s && !tick_s) begin
        pend_s = pend_r - PEND_W'(1);
      end else begin
        pend_s = pend_r;
      end
    end
  end

  // Sequencer next-state; wait_cnt restarts at zero on every wait-state entry.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (aref_req_r && aref_en) begin
          state_s = ST_PRE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (RP_CYC > 1) begin
          state_s = ST_WAIT_RP;
        end else begin
          state_s = ST_AREF;
        end
      end
      ST_WAIT_RP: begin
        if (wait_cnt_r == RP_LAST) begin
          state_s = ST_AREF;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_AREF: begin
        if (RFC_CYC > 1) begin
          state_s = ST_WAIT_RFC;
        end else begin
`ifdef AREF_BURST_EN
          state_s = (pend_s != '0) ? ST_AREF : ST_DONE;
`else
          state_s = ST_DONE;
`endif
        end
      end
      ST_WAIT_RFC: begin
        if (wait_cnt_r == RFC_LAST) begin
`ifdef AREF_BURST_EN
          state_s = (pend_r != '0) ? ST_AREF : ST_DONE;
`else
          state_s = ST_DONE;
`endif
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; command bus reflects the state held during the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      refi_cnt_r  <= '0;
      pend_r      <= '0;
      wait_cnt_r  <= '0;
      aref_req_r  <= 1'b0;
      aref_cmd_r  <= CMD_NOP;
      aref_addr_r <= '0;
      aref_end_r  <= 1'b0;
      aref_ovf_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      refi_cnt_r  <= refi_cnt_s;
      pend_r      <= pend_s;
      wait_cnt_r  <= wait_cnt_s;
      aref_req_r  <= (pend_s != '0) && (state_s == ST_IDLE);
      aref_cmd_r  <= cmd_of(state_r);
      aref_addr_r <= (state_r == ST_PRE) ? ADDR_A10 : '0;
      aref_end_r  <= (state_r == ST_DONE);
      aref_ovf_r  <= ovf_s;
    end
  end

  assign aref_req  = aref_req_r;
  assign aref_cmd  = aref_cmd_r;
  assign aref_ba   = '0;
  assign aref_addr = aref_addr_r;
  assign aref_end  = aref_end_r;
  assign aref_ovf  = aref_ovf_r;

endmodule

// File: tb/tb_ddr2_aref.sv
// Self-checking bench for ddr2_aref (tREFI=40, tRP=15, tRFC=30, tCK=5 -> 8/3/6 cycles).
// The reference model tracks the refresh timeline as offsets from the accepting grant edge.
module tb_ddr2_aref;

  localparam int REFI = 8;
  localparam int RP   = 3;
  localparam int RFC  = 6;
  localparam int MAXP = 8;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  logic        clk, rst_n, init_end, aref_en;
  logic        aref_req, aref_end, aref_ovf;
  logic [3:0]  aref_cmd;
  logic [2:0]  aref_ba;
  logic [13:0] aref_addr;

  int checks   = 0;
  int failures = 0;

  // model state
  int          m_cnt, m_pend, m_t, m_aref_t, m_end_t;
  bit          m_busy, m_req, m_ovf, e_end;
  logic [3:0]  e_cmd;
  logic [13:0] e_addr;
  logic [27:0] obs, exp_v;

  ddr2_aref #(
    .BA_BITS(3), .ADDR_BITS(14), .tCK(5), .tREFI(40), .tRP(15), .tRFC(30), .MAX_PEND(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_end(init_end), .aref_en(aref_en),
    .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr), .aref_end(aref_end), .aref_ovf(aref_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; m_t = 0; m_aref_t = 0; m_end_t = 0;
    m_busy = 1'b0; m_req = 1'b0; m_ovf = 1'b0; e_end = 1'b0;
    e_cmd = NOP; e_addr = 14'h0000;
  endtask

  // One rising edge of the reference behaviour, evaluated from pre-edge inputs.
  task automatic model_edge();
    bit tick, dec;
    int pend_pre;
    tick = init_end && (m_cnt == REFI - 1);
    dec = 1'b0;
    pend_pre = m_pend;
    e_cmd = NOP; e_addr = 14'h0000; e_end = 1'b0;
    if (m_busy) begin
      m_t++;
      if (m_t == 1) begin e_cmd = PRE; e_addr = 14'h0400; end
      if (m_t == m_aref_t) begin e_cmd = AREF; dec = (m_pend > 0); end
`ifdef AREF_BURST_EN
      if (m_t == m_aref_t + RFC - 1 && pend_pre > 0) begin
        m_aref_t += RFC;
        m_end_t = m_aref_t + RFC;
      end
`endif
      if (m_t == m_end_t) begin e_end = 1'b1; m_busy = 1'b0; end
    end else if (m_req && aref_en) begin
      m_busy = 1'b1; m_t = 0; m_aref_t = RP + 1; m_end_t = RP + 1 + RFC;
    end
    if (!init_end) m_pend = 0;
    else if (tick && !dec) begin
      if (m_pend == MAXP) m_ovf = 1'b1;
      else m_pend++;
    end else if (dec && !tick) m_pend--;
    m_cnt = !init_end ? 0 : (tick ? 0 : m_cnt + 1);
    m_req = (m_pend > 0) && !m_busy;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    obs   = {aref_req, aref_cmd, aref_addr, aref_ba, aref_end, aref_ovf, dut.pend_r};
    exp_v = {m_req, e_cmd, e_addr, 3'b000, e_end, m_ovf, 4'(m_pend)};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; init_end = 1'b0; aref_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      aref_en = 1'(($urandom % 2));
      step();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      checks++;
      if (aref_req !== 1'b0 || aref_cmd !== NOP || dut.pend_r !== 4'd0) begin
        failures++; $display("FAIL reset_idle cyc=%0d req=%b cmd=%h pend=%0d exp 0/7/0", i, aref_req, aref_cmd, dut.pend_r);
      end
    end
  endtask

  task automatic test_single();
    int req_at = -1, pre_at = -1, aref_at = -1, end_at = -1;
    do_reset();
    init_end = 1'b1; aref_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL single cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (aref_req && req_at < 0) req_at = i;
      if (aref_cmd === PRE && pre_at < 0) begin
        pre_at = i;
        checks++;
        if (aref_addr !== 14'h0400) begin failures++; $display("FAIL pre_addr got=%h exp=0400", aref_addr); end
      end
      if (aref_cmd === AREF && aref_at < 0) aref_at = i;
      if (aref_end && end_at < 0) end_at = i;
    end
    checks++;
    if (req_at != 8) begin failures++; $display("FAIL first_req got=%0d exp=8", req_at); end
    checks++;
    if (pre_at != 10) begin failures++; $display("FAIL grant_to_pre got=%0d exp=10", pre_at); end
    checks++;
    if (aref_at - pre_at != RP) begin failures++; $display("FAIL pre_to_aref got=%0d exp=%0d", aref_at - pre_at, RP); end
    checks++;
    if (end_at - aref_at != RFC) begin failures++; $display("FAIL aref_to_end got=%0d exp=%0d", end_at - aref_at, RFC); end
  endtask

  task automatic test_postpone();
    bit seen_end = 1'b0;
    do_reset();
    init_end = 1'b1; aref_en = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL postpone_fill cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    checks++;
    if (dut.pend_r !== 4'd8 || aref_ovf !== 1'b0 || aref_req !== 1'b1) begin
      failures++; $display("FAIL postpone_full pend=%0d ovf=%b req=%b exp 8/0/1", dut.pend_r, aref_ovf, aref_req);
    end
    aref_en = 1'b1;
    step();
    aref_en = 1'b0;
    for (int i = 0; i < 20 && !seen_end; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL postpone_seq cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (aref_cmd === AREF) begin
        checks++;
        if (dut.pend_r !== 4'd7) begin failures++; $display("FAIL postpone_dec pend=%0d exp=7", dut.pend_r); end
      end
      seen_end = aref_end;
    end
    checks++;
    if (!seen_end || aref_req !== 1'b1 || aref_ovf !== 1'b0) begin
      failures++; $display("FAIL postpone_end seen=%b req=%b ovf=%b exp 1/1/0", seen_end, aref_req, aref_ovf);
    end
    repeat (15) begin
      step();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL postpone_ovf_seq got=%h exp=%h", obs, exp_v); end
    end
    checks++;
    if (aref_ovf !== 1'b1 || dut.pend_r !== 4'd8) begin
      failures++; $display("FAIL overflow ovf=%b pend=%0d exp 1/8", aref_ovf, dut.pend_r);
    end
  endtask

  // Leaves the sequencer in WAIT_RFC for the asynchronous reset test that follows.
  task automatic test_coincident();
    do_reset();
    init_end = 1'b1; aref_en = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      aref_en = (i == 12);
      step();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL coincident cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 15) begin
        checks++;
        if (dut.pend_r !== 4'd1) begin failures++; $display("FAIL coinc_pre pend=%0d exp=1", dut.pend_r); end
      end
    end
    aref_en = 1'b0;
    checks++;
    if (aref_cmd !== AREF || dut.pend_r !== 4'd1) begin
      failures++; $display("FAIL coinc_edge cmd=%h pend=%0d exp 1/1", aref_cmd, dut.pend_r);
    end
  endtask

  task automatic test_async_reset();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({aref_req, aref_cmd, aref_addr, aref_ba, aref_end, aref_ovf, dut.pend_r} !== {1'b0, NOP, 14'h0000, 3'b000, 1'b0, 1'b0, 4'd0}) begin
      failures++; $display("FAIL async_reset req=%b cmd=%h addr=%h end=%b pend=%0d exp reset values", aref_req, aref_cmd, aref_addr, aref_end, dut.pend_r);
    end
    model_reset();
    init_end = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; init_end = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (aref_req !== (i == 8)) begin failures++; $display("FAIL post_reset_req cyc=%0d got=%b exp=%b", i, aref_req, (i == 8)); end
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  task automatic test_drain();
    int pre_n = 0, aref_n = 0, last_aref = -1;
    bit seen_end = 1'b0;
    do_reset();
    init_end = 1'b1; aref_en = 1'b0;
    repeat (24) step();
    checks++;
    if (dut.pend_r !== 4'd3) begin failures++; $display("FAIL drain_pend got=%0d exp=3", dut.pend_r); end
    aref_en = 1'b1;
    step();
    aref_en = 1'b0;
    for (int i = 0; i < 300 && !seen_end; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL drain_seq cyc=%0d got=%h exp=%h", i, obs, exp_v); end
      if (aref_cmd === PRE) pre_n++;
      if (aref_cmd === AREF) begin
        if (last_aref >= 0) begin
          checks++;
          if (i - last_aref != RFC) begin failures++; $display("FAIL aref_spacing got=%0d exp=%0d", i - last_aref, RFC); end
        end
        last_aref = i; aref_n++;
      end
      seen_end = aref_end;
    end
    checks++;
    if (!seen_end || pre_n != 1) begin failures++; $display("FAIL drain_end seen=%b pre=%0d exp 1/1", seen_end, pre_n); end
`ifdef AREF_BURST_EN
    checks++;
    if (aref_n < 3) begin failures++; $display("FAIL burst_count got=%0d exp>=3", aref_n); end
`else
    checks++;
    if (aref_n != 1 || aref_req !== 1'b1) begin failures++; $display("FAIL single_count aref=%0d req=%b exp 1/1", aref_n, aref_req); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    init_end = 1'b1;
    for (int i = 0; i < 600; i++) begin
      aref_en = ($urandom_range(0, 9) < 2);
      step();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    rst_n = 1'b0; init_end = 1'b0; aref_en = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_postpone();
    test_coincident();
    test_async_reset();
    test_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
